// File: rtl/srambank_rmw_ctrl.sv
// srambank_rmw_ctrl
//   Request front-end for one synchronous SRAM bank (256 x 80 by default).
//   Reads are forwarded to the bank and the result is returned over a
//   valid/ready response port. Full-mask writes go straight to the bank.
//   Partial-mask writes become read / merge / write sequences, so the bank
//   only ever sees full-word writes. One request is in flight at a time.
//   DATA_W must be an integer multiple of LANE_W.

module srambank_rmw_ctrl #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 80,
   parameter int LANE_W = 8,
   localparam int NL    = DATA_W / LANE_W
) (
   input  logic              clk,
   input  logic              reset,
   // request port
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [NL-1:0]     req_mask,
   // response port
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   // bank pins
   output logic [ADDR_W-1:0] bank_address,
   output logic [DATA_W-1:0] bank_wd,
   output logic              bank_banksel,
   output logic              bank_read,
   output logic              bank_write,
   input  logic [DATA_W-1:0] bank_dataout
);

   typedef enum logic [2:0] {
      ST_IDLE,   // waiting for a request
      ST_RD,     // bank read of a plain read is on the pins
      ST_RSP,    // read data offered on the response port
      ST_PRD,    // bank read of a read-modify-write is on the pins
      ST_PMRG,   // old word arrives on bank_dataout; merge into bank_wd
      ST_WR      // bank write is on the pins
   } state_t;

   state_t              state_q;
   logic                bank_read_q;
   logic                bank_write_q;
   logic                bank_sel_q;
   logic [ADDR_W-1:0]   bank_addr_q;
   logic [DATA_W-1:0]   bank_wd_q;
   logic                rsp_valid_q;

   logic [DATA_W-1:0]   wdata_q;
   logic [NL-1:0]       mask_q;
   logic [DATA_W-1:0]   merge_d;

   logic                accept;

   assign accept = req_valid && (state_q == ST_IDLE);

   // Lane-wise merge of the latched write data over the word just read back.
   always_comb begin
      merge_d = bank_dataout;
      for (int i = 0; i < NL; i++) begin
         if (mask_q[i]) begin
            merge_d[i*LANE_W +: LANE_W] = wdata_q[i*LANE_W +: LANE_W];
         end
      end
   end

   // Request payload capture; only consumed on the merge path.
   // NOTE: these are pure data holding registers qualified by the FSM, so
   // they carry no reset; a stale value is never used before a fresh capture.
   always_ff @(posedge clk) begin
      if (accept) begin
         wdata_q <= req_wdata;
         mask_q  <= req_mask;
      end
   end

   // Sequencer: state plus every registered bank/response output.
   // NOTE: all state here uses non-blocking assignments so every register
   // samples the pre-edge values, regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         bank_read_q  <= 1'b0;
         bank_write_q <= 1'b0;
         bank_sel_q   <= 1'b0;
         bank_addr_q  <= '0;
         bank_wd_q    <= '0;
         rsp_valid_q  <= 1'b0;
      end else begin
         // bank commands are single-cycle pulses unless re-armed below
         bank_read_q  <= 1'b0;
         bank_write_q <= 1'b0;
         bank_sel_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  bank_addr_q <= req_addr;
                  if (!req_write) begin
                     state_q     <= ST_RD;
                     bank_read_q <= 1'b1;
                     bank_sel_q  <= 1'b1;
                  end else if (&req_mask) begin
                     state_q      <= ST_WR;
                     bank_write_q <= 1'b1;
                     bank_sel_q   <= 1'b1;
                     bank_wd_q    <= req_wdata;
                  end else if (|req_mask) begin
                     state_q     <= ST_PRD;
                     bank_read_q <= 1'b1;
                     bank_sel_q  <= 1'b1;
                  end
                  // empty-mask write: retired here with no bank access
               end
            end
            ST_RD: begin
               state_q     <= ST_RSP;
               rsp_valid_q <= 1'b1;
            end
            ST_RSP: begin
               if (rsp_ready) begin
                  state_q     <= ST_IDLE;
                  rsp_valid_q <= 1'b0;
               end
            end
            ST_PRD: begin
               state_q <= ST_PMRG;
            end
            ST_PMRG: begin
               state_q      <= ST_WR;
               bank_wd_q    <= merge_d;
               bank_write_q <= 1'b1;
               bank_sel_q   <= 1'b1;
            end
            ST_WR: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready    = (state_q == ST_IDLE);
   assign rsp_valid    = rsp_valid_q;
   // bank_dataout is held by the bank until the next read, and no read is
   // issued while a response is pending, so a direct pass-through is stable.
   assign rsp_data     = bank_dataout;
   assign bank_address = bank_addr_q;
   assign bank_wd      = bank_wd_q;
   assign bank_banksel = bank_sel_q;
   assign bank_read    = bank_read_q;
   assign bank_write   = bank_write_q;

endmodule
